// File: rtl/weight_load_sched_1x8.sv
// weight_load_sched_1x8: load/read sequencer for the 8-bank 3x3 weight buffer.
// Load side deals 36-bit kernels round-robin across 8 banks, one address per
// group of 8. Read side sweeps a shared address over the loaded region and
// flags the RAM output one cycle later to cover the read latency.
module weight_load_sched_1x8 #(
    parameter int ADDR_BIT = 9,
    parameter int DEPTH    = 512
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_BIT-1:0] cfg_base,
    input  logic [ADDR_BIT:0]   cfg_groups,
    input  logic                load_start,
    input  logic                w_valid,
    output logic                w_ready,
    input  logic [35:0]         w_data,
    output logic [ADDR_BIT-1:0] write_addr,
    output logic [7:0]          write_en,
    output logic [35:0]         weight_in,
    output logic                load_busy,
    output logic                load_done,
    input  logic                rd_start,
    output logic [ADDR_BIT-1:0] read_addr,
    output logic                rd_valid,
    output logic                rd_last,
    output logic                rd_busy
);

    localparam logic [ADDR_BIT:0] DEPTH_W = (ADDR_BIT+1)'(DEPTH);

    typedef enum logic [1:0] {L_IDLE, L_LOAD, L_DONE} lstate_t;
    typedef enum logic       {R_IDLE, R_RUN}          rstate_t;

    lstate_t             lstate;
    rstate_t             rstate;
    logic [ADDR_BIT-1:0] base_q;
    logic [ADDR_BIT:0]   groups_q;
    logic [2:0]          bank_q;
    logic [ADDR_BIT:0]   group_q;
    logic [ADDR_BIT:0]   rd_idx;
    logic                issue_last;

    logic load_go, rd_go, beat, last_beat;

    // A load may not start while a sweep is reading the banks; group counts
    // larger than the bank depth are rejected like a zero count.
    assign load_go   = load_start && (lstate == L_IDLE) && !rd_busy &&
                       (cfg_groups != '0) && (cfg_groups <= DEPTH_W);
    // Load wins a same-cycle collision, so a starting load suppresses the read.
    assign rd_go     = rd_start && (rstate == R_IDLE) && !rd_busy && !load_busy &&
                       (groups_q != '0) && !load_go;
    assign w_ready   = (lstate == L_LOAD);
    assign beat      = w_valid && w_ready;
    assign last_beat = (bank_q == 3'd7) && (group_q == groups_q - 1'b1);

    // Load FSM: latch region, accept beats, register the bank write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lstate     <= L_IDLE;
            base_q     <= '0;
            groups_q   <= '0;
            bank_q     <= '0;
            group_q    <= '0;
            write_addr <= '0;
            write_en   <= '0;
            weight_in  <= '0;
            load_busy  <= 1'b0;
            load_done  <= 1'b0;
        end else begin
            write_en  <= '0;
            load_done <= 1'b0;
            case (lstate)
                L_IDLE: begin
                    if (load_go) begin
                        lstate    <= L_LOAD;
                        base_q    <= cfg_base;
                        groups_q  <= cfg_groups;
                        bank_q    <= '0;
                        group_q   <= '0;
                        load_busy <= 1'b1;
                    end
                end
                L_LOAD: begin
                    if (beat) begin
                        weight_in  <= w_data;
                        write_en   <= 8'b1 << bank_q;
                        write_addr <= base_q + group_q[ADDR_BIT-1:0];
                        bank_q     <= bank_q + 3'd1;
                        if (bank_q == 3'd7)
                            group_q <= group_q + 1'b1;
                        // Final write and done pulse land in the same cycle.
                        if (last_beat) begin
                            lstate    <= L_DONE;
                            load_done <= 1'b1;
                        end
                    end
                end
                L_DONE: begin
                    lstate    <= L_IDLE;
                    load_busy <= 1'b0;
                end
                default: lstate <= L_IDLE;
            endcase
        end
    end

    // Read FSM: issue one address per cycle in RUN; rd_valid trails issue by
    // one cycle, and rd_busy covers the trailing drain cycle after RUN ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rstate     <= R_IDLE;
            read_addr  <= '0;
            rd_idx     <= '0;
            issue_last <= 1'b0;
            rd_valid   <= 1'b0;
            rd_last    <= 1'b0;
            rd_busy    <= 1'b0;
        end else begin
            rd_valid <= (rstate == R_RUN);
            rd_last  <= (rstate == R_RUN) && issue_last;
            case (rstate)
                R_IDLE: begin
                    rd_busy    <= 1'b0;
                    issue_last <= 1'b0;
                    if (rd_go) begin
                        rstate     <= R_RUN;
                        read_addr  <= base_q;
                        rd_idx     <= (ADDR_BIT+1)'(1);
                        issue_last <= (groups_q == (ADDR_BIT+1)'(1));
                        rd_busy    <= 1'b1;
                    end
                end
                R_RUN: begin
                    rd_busy <= 1'b1;
                    if (issue_last) begin
                        rstate     <= R_IDLE;
                        issue_last <= 1'b0;
                    end else begin
                        read_addr  <= read_addr + 1'b1;
                        rd_idx     <= rd_idx + 1'b1;
                        issue_last <= (rd_idx == groups_q - 1'b1);
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_weight_load_sched_1x8.sv
// Bench for weight_load_sched_1x8: table of load+sweep scenarios against a
// behavioural 8-bank RAM, plus hand-written reset and collision sequences.
module tb_weight_load_sched_1x8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [8:0]  cfg_base = '0;
    logic [9:0]  cfg_groups = '0;
    logic        load_start = 1'b0;
    logic        w_valid = 1'b0;
    logic        w_ready;
    logic [35:0] w_data = '0;
    logic [8:0]  write_addr;
    logic [7:0]  write_en;
    logic [35:0] weight_in;
    logic        load_busy, load_done;
    logic        rd_start = 1'b0;
    logic [8:0]  read_addr;
    logic        rd_valid, rd_last, rd_busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    weight_load_sched_1x8 #(.ADDR_BIT(9), .DEPTH(512)) dut (
        .clk(clk), .rst(rst),
        .cfg_base(cfg_base), .cfg_groups(cfg_groups), .load_start(load_start),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .write_addr(write_addr), .write_en(write_en), .weight_in(weight_in),
        .load_busy(load_busy), .load_done(load_done),
        .rd_start(rd_start), .read_addr(read_addr),
        .rd_valid(rd_valid), .rd_last(rd_last), .rd_busy(rd_busy)
    );

    // Behavioural weight buffer: 8 banks, synchronous write, 1-cycle read.
    logic [35:0] mem [0:7][0:511];
    logic [35:0] q   [0:7];
    always @(posedge clk) begin
        for (int n = 0; n < 8; n++) begin
            if (write_en[n]) mem[n][write_addr] <= weight_in;
            q[n] <= mem[n][read_addr];
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [35:0] pat(input int seed, input int k);
        return {4'(seed), 32'(seed * 4096 + k) ^ 32'h5A5A_0000};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " w_ready"},    w_ready,    0);
        chk({tag, " write_addr"}, write_addr, 0);
        chk({tag, " write_en"},   write_en,   0);
        chk({tag, " weight_in"},  weight_in,  0);
        chk({tag, " load_busy"},  load_busy,  0);
        chk({tag, " load_done"},  load_done,  0);
        chk({tag, " read_addr"},  read_addr,  0);
        chk({tag, " rd_valid"},   rd_valid,   0);
        chk({tag, " rd_last"},    rd_last,    0);
        chk({tag, " rd_busy"},    rd_busy,    0);
    endtask

    // Drive one load; checks every write-port cycle, done timing and RAM image.
    task automatic do_load(input logic [8:0] base, input logic [9:0] groups, input bit gap,
                           input int seed, input int poke, input bit with_rd, input int exp_cyc);
        int  k, cyc;
        bit  acc, done, v;
        @(negedge clk);
        cfg_base = base; cfg_groups = groups; load_start = 1'b1; rd_start = with_rd;
        @(negedge clk);
        load_start = 1'b0; rd_start = 1'b0;
        chk("load_busy after start", load_busy, 1);
        k = 0; cyc = 0; done = 0;
        while (!done && cyc < 200) begin
            v = (k < groups * 8) && (!gap || (cyc % 2 == 0));
            w_valid = v;
            w_data  = v ? pat(seed, k) : 36'hF_FFFF_FFFF;
            if (cyc == poke) begin
                load_start = 1'b1; cfg_base = base + 9'd100; cfg_groups = groups + 10'd1;
            end else begin
                load_start = 1'b0;
            end
            acc = v && w_ready;
            @(negedge clk);
            cyc++;
            if (acc) begin
                chk("write_en", write_en, 8'b1 << (k % 8));
                chk("write_addr", write_addr, 9'(base + k / 8));
                chk("weight_in", weight_in, pat(seed, k));
                k++;
            end else begin
                chk("write_en bubble", write_en, 0);
            end
            if (with_rd) chk("rd_busy during load", rd_busy, 0);
            if (load_done) begin
                done = 1;
                chk("beats at load_done", k, groups * 8);
                chk("w_ready in done", w_ready, 0);
            end
        end
        w_valid = 1'b0; load_start = 1'b0;
        chk("load_done cycle", cyc, exp_cyc);
        @(negedge clk);
        chk("load_busy after done", load_busy, 0);
        chk("load_done single pulse", load_done, 0);
        for (int i = 0; i < groups * 8; i++)
            chk("ram contents", mem[i % 8][9'(base + i / 8)], pat(seed, i));
    endtask

    // One read sweep; a load_start is thrown in mid-sweep and must be ignored.
    task automatic do_read(input logic [8:0] base, input logic [9:0] groups, input int seed);
        int busy_n;
        busy_n = 0;
        @(negedge clk);
        rd_start = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
        for (int c = 1; c <= groups + 3; c++) begin
            if (c == 1) begin
                cfg_groups = 10'd1; load_start = 1'b1;
            end else begin
                load_start = 1'b0;
            end
            if (c <= groups) chk("read_addr", read_addr, 9'(base + c - 1));
            chk("rd_valid", rd_valid, (c >= 2) && (c <= groups + 1));
            chk("rd_last", rd_last, c == groups + 1);
            chk("load_busy during read", load_busy, 0);
            chk("write_en during read", write_en, 0);
            if (rd_busy) busy_n++;
            if (rd_valid)
                for (int n = 0; n < 8; n++)
                    chk("weight_out", q[n], pat(seed, (c - 2) * 8 + n));
            @(negedge clk);
        end
        load_start = 1'b0;
        chk("rd_busy cycles", busy_n, groups + 1);
        chk("read_addr hold", read_addr, 9'(base + groups - 1));
    endtask

    typedef struct {
        logic [8:0] base;
        logic [9:0] groups;
        bit         gap;
        int         seed;
        int         poke;
        bit         with_rd;
        int         exp_cyc;
    } vec_t;

    vec_t tbl [6];

    initial begin
        //          base    groups  gap seed poke rd  done-cycle
        tbl[0] = '{9'd0,   10'd2,  0,  1,   -1,  0,  16};
        tbl[1] = '{9'd0,   10'd2,  1,  2,   -1,  0,  31};
        tbl[2] = '{9'd510, 10'd4,  0,  3,   -1,  0,  32};
        tbl[3] = '{9'd5,   10'd3,  0,  4,   -1,  0,  24};
        tbl[4] = '{9'd200, 10'd1,  0,  5,    3,  0,   8};
        tbl[5] = '{9'd40,  10'd1,  1,  6,   -1,  1,  15};

        // Reset values
        repeat (2) @(negedge clk);
        chk_zero("in reset");
        rst = 1'b0;
        @(negedge clk);
        chk_zero("after reset");

        // rd_start with nothing loaded is ignored
        rd_start = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
        @(negedge clk);
        chk("rd_busy empty", rd_busy, 0);
        chk("rd_valid empty", rd_valid, 0);

        // load_start with zero groups is ignored
        cfg_groups = 10'd0; load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        chk("groups0 load_busy", load_busy, 0);
        chk("groups0 w_ready", w_ready, 0);
        @(negedge clk);
        chk("groups0 load_done", load_done, 0);

        for (int i = 0; i < 6; i++) begin
            do_load(tbl[i].base, tbl[i].groups, tbl[i].gap, tbl[i].seed,
                    tbl[i].poke, tbl[i].with_rd, tbl[i].exp_cyc);
            do_read(tbl[i].base, tbl[i].groups, tbl[i].seed);
        end

        // Reset after 5 of 16 beats
        @(negedge clk);
        cfg_base = 9'd0; cfg_groups = 10'd2; load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            w_valid = 1'b1; w_data = pat(9, i);
            @(negedge clk);
        end
        chk("write_en before rst", write_en, 8'b0001_0000);
        rst = 1'b1;
        #1;
        chk_zero("mid-load reset");
        w_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post-reset load_done", load_done, 0);
            chk("post-reset load_busy", load_busy, 0);
            chk("post-reset w_ready", w_ready, 0);
        end

        // Fresh load after reset completes normally
        do_load(9'd0, 10'd2, 0, 10, -1, 0, 16);
        do_read(9'd0, 10'd2, 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
